pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the `enable` and `reset` (flush) pins of the four pipeline registers: fetch/decode, decode/execute, execute/memory and memory/writeback. It also drives the PC register enable. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, halts the core on a memory timeout, and keeps saturating stall/flush statistics.

---
 rtl/pipeline_hazard_controller.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, data-memory wait stalls with timeout halt, and saturating statistics.
module pipeline_hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  dec_srca,
    input  logic [4:0]  dec_srcb,
    input  logic        dec_usesa,
    input  logic        dec_usesb,
    input  logic        ex_isload,
    input  logic [4:0]  ex_dest,
    input  logic        ex_branchtaken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_enable,
    output logic        fd_enable,
    output logic        de_enable,
    output logic        em_enable,
    output logic        mw_enable,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        em_flush,
    output logic        mw_flush,
    output logic        mem_error,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = MEM_TIMEOUT[15:0];

    state_t      state_r, state_next_s;
    logic [15:0] wait_cnt_r, wait_next_s;
    logic [15:0] stall_count_r, flush_count_r;
    logic        mem_error_r;
    logic        memstall_s, loaduse_s;
    logic        pc_en_s, fd_en_s, de_en_s, em_en_s, mw_en_s;
    logic        fd_fl_s, de_fl_s, em_fl_s, mw_fl_s;
    logic        err_set_s, stall_inc_s, flush_inc_s;

    assign memstall_s = mem_req & ~mem_ready;
    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign loaduse_s  = ex_isload && (ex_dest != 5'd0) &&
                        ((dec_usesa && (dec_srca == ex_dest)) ||
                         (dec_usesb && (dec_srcb == ex_dest)));

    // Next-state, wait counter and Mealy stall/flush decode.
    always_comb begin
        pc_en_s      = 1'b1;
        fd_en_s      = 1'b1;
        de_en_s      = 1'b1;
        em_en_s      = 1'b1;
        mw_en_s      = 1'b1;
        fd_fl_s      = 1'b0;
        de_fl_s      = 1'b0;
        em_fl_s      = 1'b0;
        mw_fl_s      = 1'b0;
        state_next_s = state_r;
        wait_next_s  = wait_cnt_r;
        err_set_s    = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        case (state_r)
            ST_RUN, ST_MEMWAIT: begin
                if (memstall_s) begin
                    pc_en_s     = 1'b0;
                    fd_en_s     = 1'b0;
                    de_en_s     = 1'b0;
                    em_en_s     = 1'b0;
                    mw_fl_s     = 1'b1;
                    stall_inc_s = 1'b1;
                    if (state_r == ST_RUN) begin
                        wait_next_s = 16'd1;
                        if (TIMEOUT_C == 16'd1) begin
                            state_next_s = ST_HALT;
                            err_set_s    = 1'b1;
                        end else begin
                            state_next_s = ST_MEMWAIT;
                        end
                    end else if ((wait_cnt_r + 16'd1) == TIMEOUT_C) begin
                        // This cycle is the last tolerated stall cycle.
                        state_next_s = ST_HALT;
                        err_set_s    = 1'b1;
                    end else begin
                        wait_next_s  = wait_cnt_r + 16'd1;
                        state_next_s = ST_MEMWAIT;
                    end
                end else begin
                    state_next_s = ST_RUN;
                    wait_next_s  = 16'd0;
                    if (ex_branchtaken) begin
                        fd_fl_s     = 1'b1;
                        de_fl_s     = 1'b1;
                        flush_inc_s = 1'b1;
                    end else if (loaduse_s) begin
                        pc_en_s     = 1'b0;
                        fd_en_s     = 1'b0;
                        de_fl_s     = 1'b1;
                        stall_inc_s = 1'b1;
                    end else begin
                        fd_fl_s = 1'b0;
                    end
                end
            end
            ST_HALT: begin
                pc_en_s = 1'b0;
                fd_en_s = 1'b0;
                de_en_s = 1'b0;
                em_en_s = 1'b0;
                mw_en_s = 1'b0;
            end
            default: begin
                pc_en_s      = 1'b0;
                fd_en_s      = 1'b0;
                de_en_s      = 1'b0;
                em_en_s      = 1'b0;
                mw_en_s      = 1'b0;
                state_next_s = ST_HALT;
                err_set_s    = 1'b1;
            end
        endcase
    end

    // State, wait counter, sticky error and saturating statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= 16'd0;
            mem_error_r   <= 1'b0;
            stall_count_r <= 16'd0;
            flush_count_r <= 16'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
            if (err_set_s) begin
                mem_error_r <= 1'b1;
            end
            if (stall_inc_s && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
            if (flush_inc_s && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'd1;
            end
        end
    end

    // While reset is held every register is enabled and cleared.
    assign pc_enable   = reset | pc_en_s;
    assign fd_enable   = reset | fd_en_s;
    assign de_enable   = reset | de_en_s;
    assign em_enable   = reset | em_en_s;
    assign mw_enable   = reset | mw_en_s;
    assign fd_flush    = reset | fd_fl_s;
    assign de_flush    = reset | de_fl_s;
    assign em_flush    = reset | em_fl_s;
    assign mw_flush    = reset | mw_fl_s;
    assign mem_error   = mem_error_r;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (short and long timeout)
// checked every cycle against a rule-level model, plus directed literal checks.
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] dec_srca, dec_srcb, ex_dest;
    logic       dec_usesa, dec_usesb, ex_isload, ex_branchtaken, mem_req, mem_ready;

    logic [8:0]  ctl [2];
    logic        err [2];
    logic [15:0] scnt [2];
    logic [15:0] fcnt [2];

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .dec_srca(dec_srca), .dec_srcb(dec_srcb),
        .dec_usesa(dec_usesa), .dec_usesb(dec_usesb),
        .ex_isload(ex_isload), .ex_dest(ex_dest),
        .ex_branchtaken(ex_branchtaken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(ctl[0][8]), .fd_enable(ctl[0][7]), .de_enable(ctl[0][6]),
        .em_enable(ctl[0][5]), .mw_enable(ctl[0][4]),
        .fd_flush(ctl[0][3]), .de_flush(ctl[0][2]), .em_flush(ctl[0][1]), .mw_flush(ctl[0][0]),
        .mem_error(err[0]), .stall_count(scnt[0]), .flush_count(fcnt[0])
    );

    pipeline_hazard_controller #(.MEM_TIMEOUT(65535)) dut_sat (
        .clock(clock), .reset(reset),
        .dec_srca(dec_srca), .dec_srcb(dec_srcb),
        .dec_usesa(dec_usesa), .dec_usesb(dec_usesb),
        .ex_isload(ex_isload), .ex_dest(ex_dest),
        .ex_branchtaken(ex_branchtaken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_enable(ctl[1][8]), .fd_enable(ctl[1][7]), .de_enable(ctl[1][6]),
        .em_enable(ctl[1][5]), .mw_enable(ctl[1][4]),
        .fd_flush(ctl[1][3]), .de_flush(ctl[1][2]), .em_flush(ctl[1][1]), .mw_flush(ctl[1][0]),
        .mem_error(err[1]), .stall_count(scnt[1]), .flush_count(fcnt[1])
    );

    // ---------------- model ----------------
    // mode: 0 running, 1 waiting on memory, 2 halted; n = stall cycles in this wait
    int m_timeout [2] = '{4, 65535};
    int m_mode  [2];
    int m_n     [2];
    int m_err   [2];
    int m_stall [2];
    int m_flush [2];
    bit m_valid = 1'b0;

    function automatic bit f_memstall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit f_loaduse();
        return ex_isload && (ex_dest != 5'd0) &&
               ((dec_usesa && dec_srca == ex_dest) || (dec_usesb && dec_srcb == ex_dest));
    endfunction

    // bit order {pc,fd,de,em,mw enables, fd,de,em,mw flushes}
    function automatic logic [8:0] f_exp_ctl(int mode);
        if (reset)                 return 9'b11111_1111;
        if (mode == 2)             return 9'b00000_0000;
        if (f_memstall())          return 9'b00001_0001;
        if (ex_branchtaken)        return 9'b11111_1100;
        if (f_loaduse())           return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Model update at each rising edge from the inputs of the ending cycle.
    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int mode, n, e, s, f;
            mode = m_mode[i]; n = m_n[i]; e = m_err[i]; s = m_stall[i]; f = m_flush[i];
            if (reset) begin
                mode = 0; n = 0; e = 0; s = 0; f = 0;
            end else if (mode != 2) begin
                if (f_memstall()) begin
                    n = (mode == 0) ? 1 : n + 1;
                    s = sat_inc(s);
                    if (n == m_timeout[i]) begin
                        mode = 2; e = 1;
                    end else begin
                        mode = 1;
                    end
                end else begin
                    mode = 0; n = 0;
                    if (ex_branchtaken) f = sat_inc(f);
                    else if (f_loaduse()) s = sat_inc(s);
                end
            end
            m_mode[i] <= mode; m_n[i] <= n; m_err[i] <= e; m_stall[i] <= s; m_flush[i] <= f;
        end
        if (reset) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ctl[%0d]", i), {23'd0, ctl[i]}, {23'd0, f_exp_ctl(m_mode[i])});
                chk($sformatf("mem_error[%0d]", i), {31'd0, err[i]}, m_err[i]);
                chk($sformatf("stall_count[%0d]", i), {16'd0, scnt[i]}, m_stall[i]);
                chk($sformatf("flush_count[%0d]", i), {16'd0, fcnt[i]}, m_flush[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle();
        dec_srca = 5'd0; dec_srcb = 5'd0; dec_usesa = 1'b0; dec_usesb = 1'b0;
        ex_isload = 1'b0; ex_dest = 5'd0; ex_branchtaken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic rand_in();
        dec_srca = 5'($urandom_range(0, 3)); dec_srcb = 5'($urandom_range(0, 3));
        ex_dest  = 5'($urandom_range(0, 3));
        dec_usesa = 1'($urandom); dec_usesb = 1'($urandom); ex_isload = 1'($urandom);
        ex_branchtaken = ($urandom_range(0, 3) == 0);
        mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        reset = 1'b1;
        rand_in();
        tick(1);
        rand_in();
        #1 chk("reset_ctl", {23'd0, ctl[0]}, 32'h1FF);
        tick(1);
        reset = 1'b0;
        idle();
        #1;
        chk("post_reset_ctl", {23'd0, ctl[0]}, 32'h1F0);
        chk("post_reset_err", {31'd0, err[0]}, 32'd0);
        chk("post_reset_stall", {16'd0, scnt[0]}, 32'd0);

        // load-use on source b, then the same with destination register 0
        ex_isload = 1'b1; ex_dest = 5'd5; dec_usesb = 1'b1; dec_srcb = 5'd5;
        #1 chk("loaduse_ctl", {23'd0, ctl[0]}, 32'h074);
        tick(1);
        idle();
        chk("loaduse_stall", {16'd0, scnt[0]}, 32'd1);
        ex_isload = 1'b1; ex_dest = 5'd0; dec_usesb = 1'b1; dec_srcb = 5'd0;
        #1 chk("r0_nostall", {31'd0, ctl[0][8]}, 32'd1);
        tick(1);
        idle();

        // branch together with load-use: branch wins
        ex_isload = 1'b1; ex_dest = 5'd7; dec_usesa = 1'b1; dec_srca = 5'd7; ex_branchtaken = 1'b1;
        #1 chk("br_lu_ctl", {23'd0, ctl[0]}, 32'h1FC);
        tick(1);
        idle();
        chk("br_lu_flush", {16'd0, fcnt[0]}, 32'd1);
        chk("br_lu_stall", {16'd0, scnt[0]}, 32'd1);

        // three-cycle memory wait, then release; once plain, once with a frozen branch
        for (int rep = 0; rep < 2; rep++) begin
            mem_req = 1'b1; mem_ready = 1'b0; ex_branchtaken = (rep == 1);
            for (int c = 0; c < 3; c++) begin
                #1 chk("memwait_ctl", {23'd0, ctl[0]}, 32'h011);
                tick(1);
            end
            mem_ready = 1'b1;
            #1 chk("release_ctl", {23'd0, ctl[0]}, (rep == 1) ? 32'h1FC : 32'h1F0);
            tick(1);
            idle();
        end
        chk("memwait_stall", {16'd0, scnt[0]}, 32'd7);
        chk("memwait_flush", {16'd0, fcnt[0]}, 32'd2);

        // random traffic, checked by the model only
        for (int c = 0; c < 400; c++) begin
            rand_in();
            reset = ($urandom_range(0, 60) == 0);
            tick(1);
        end
        reset = 1'b1;
        idle();
        tick(1);
        reset = 1'b0;

        // timeout on the short instance; the long instance keeps stalling toward saturation
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(4);
        #1;
        chk("halt_err", {31'd0, err[0]}, 32'd1);
        chk("halt_ctl", {23'd0, ctl[0]}, 32'h000);
        chk("halt_stall", {16'd0, scnt[0]}, 32'd4);
        tick(64996);
        mem_ready = 1'b1;
        tick(1);
        mem_ready = 1'b0;
        tick(600);
        #1;
        chk("sat_stall", {16'd0, scnt[1]}, 32'h0000FFFF);
        chk("halt_hold_err", {31'd0, err[0]}, 32'd1);
        chk("halt_hold_stall", {16'd0, scnt[0]}, 32'd4);

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        idle();
        #1;
        chk("rerun_ctl", {23'd0, ctl[0]}, 32'h1F0);
        chk("rerun_err", {31'd0, err[0]}, 32'd0);
        chk("rerun_stall", {16'd0, scnt[1]}, 32'd0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
